// File: rtl/timer_device_pkg.sv
`default_nettype none
// ============================================================================
// Package  : timer_device_pkg
// Brief    : Register map, CTRL field positions, mode codes and FSM states
//            shared by the countdown timer and its bus-side users.
// Revision : 1.0  initial release
// ============================================================================
package timer_device_pkg;

    // Register select codes, taken from word address bits [3:2]
    localparam logic [1:0] c_reg_ctrl   = 2'd0;
    localparam logic [1:0] c_reg_preset = 2'd1;
    localparam logic [1:0] c_reg_count  = 2'd2;

    localparam int c_ctrl_en      = 0;
    localparam int c_ctrl_mode_lo = 1;
    localparam int c_ctrl_mode_hi = 2;
    localparam int c_ctrl_im      = 3;

    // Only this exact code reloads; 2'b1x falls back to one-shot
    localparam logic [1:0] c_mode_reload = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_e;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) result[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_device.sv
`default_nettype none
// ============================================================================
// Module   : timer_device
// Brief    : Memory-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot
//            or auto-reload modes and a maskable interrupt output.
// Revision : 1.0  initial release
// ============================================================================
module timer_device
    import timer_device_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]       r_ctrl_q,   w_ctrl_d;
    logic [CNT_W-1:0] r_preset_q, w_preset_d;
    logic [CNT_W-1:0] r_count_q,  w_count_d;
    state_e           r_state_q,  w_state_d;
    logic             r_irq_q,    w_irq_d;

    logic [1:0] w_sel;
    logic       w_wr_ctrl;
    logic       w_wr_preset;
    logic       w_en;
    logic       w_reload;
    logic       w_unused_addr;

    assign w_sel         = addr[3:2];
    assign w_wr_ctrl     = (|byteen) && (w_sel == c_reg_ctrl);
    assign w_wr_preset   = (|byteen) && (w_sel == c_reg_preset);
    assign w_en          = r_ctrl_q[c_ctrl_en];
    assign w_reload      = (r_ctrl_q[c_ctrl_mode_hi:c_ctrl_mode_lo] == c_mode_reload);
    assign w_unused_addr = ^{addr[29:4], addr[1:0]};

    assign irq = r_irq_q & r_ctrl_q[c_ctrl_im];

    always_comb begin
        rdata = 32'd0;
        case (w_sel)
            c_reg_ctrl:   rdata = {28'd0, r_ctrl_q};
            c_reg_preset: rdata = 32'(r_preset_q);
            c_reg_count:  rdata = 32'(r_count_q);
            default:      rdata = 32'd0;
        endcase
    end

    // FSM decisions use the registered CTRL; a same-edge write lands in CTRL
    // but only steers the state machine from the following edge.
    always_comb begin
        w_ctrl_d   = r_ctrl_q;
        w_preset_d = r_preset_q;
        w_count_d  = r_count_q;
        w_state_d  = r_state_q;
        w_irq_d    = r_irq_q;

        if (w_wr_ctrl && byteen[0]) w_ctrl_d = wdata[3:0];
        if (w_wr_preset) w_preset_d = CNT_W'(merge_bytes(32'(r_preset_q), wdata, byteen));

        case (r_state_q)
            S_IDLE: begin
                if (w_en) w_state_d = S_LOAD;
            end
            S_LOAD: begin
                w_count_d = r_preset_q;
                w_state_d = w_en ? S_CNT : S_IDLE;
                if (w_reload) w_irq_d = 1'b0;
            end
            S_CNT: begin
                if (!w_en) begin
                    w_state_d = S_IDLE;
                end else if (r_count_q > CNT_W'(1)) begin
                    w_count_d = r_count_q - CNT_W'(1);
                end else begin
                    w_count_d = '0;
                    w_state_d = S_INT;
                end
            end
            S_INT: begin
                w_irq_d = 1'b1;
                if (w_reload) begin
                    w_state_d = S_LOAD;
                end else begin
                    w_ctrl_d[c_ctrl_en] = 1'b0;
                    w_state_d           = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        // Software acknowledge beats a coincident expiry
        if (w_wr_ctrl || w_wr_preset) w_irq_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl_q   <= 4'd0;
            r_preset_q <= '0;
            r_count_q  <= '0;
            r_state_q  <= S_IDLE;
            r_irq_q    <= 1'b0;
        end else begin
            r_ctrl_q   <= w_ctrl_d;
            r_preset_q <= w_preset_d;
            r_count_q  <= w_count_d;
            r_state_q  <= w_state_d;
            r_irq_q    <= w_irq_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_device.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_device
// Brief    : Directed self-checking bench for timer_device.
// Revision : 1.0  initial release
// ============================================================================
module tb_timer_device;

    logic        clk;
    logic        reset;
    logic [29:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int tests = 0;
    int fails = 0;

    timer_device #(.CNT_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic rd_check(input string tag, input logic [3:0] ofs, input logic [31:0] exp);
        addr = 30'(ofs);
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic irq_check(input string tag, input logic exp);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    // One bus write, committed at the next rising edge; returns 1 time unit after it
    task automatic bus_wr(input logic [3:0] ofs, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        addr   = 30'(ofs);
        byteen = be;
        wdata  = d;
        @(posedge clk);
        #1;
        byteen = 4'b0000;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        addr   = '0;
        byteen = 4'b0000;
        wdata  = '0;

        // 1. reset values
        repeat (2) @(posedge clk);
        #1;
        irq_check("rst_irq_low", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(1);
        rd_check("rst_ctrl", 4'h0, 32'h0);
        rd_check("rst_preset", 4'h4, 32'h0);
        rd_check("rst_count", 4'h8, 32'h0);
        irq_check("rst_irq", 1'b0);

        // 2. one-shot, N=5
        bus_wr(4'h4, 4'hF, 32'd5);
        bus_wr(4'h0, 4'hF, 32'h9);
        step(2);
        rd_check("os_count_e2", 4'h8, 32'd5);
        step(4);
        rd_check("os_count_e6", 4'h8, 32'd1);
        step(1);
        rd_check("os_count_e7", 4'h8, 32'd0);
        irq_check("os_irq_e7", 1'b0);
        step(1);
        irq_check("os_irq_e8", 1'b1);
        rd_check("os_ctrl_e8", 4'h0, 32'h8);
        step(2);
        irq_check("os_irq_sticky", 1'b1);
        bus_wr(4'h0, 4'hF, 32'h0);
        irq_check("os_irq_cleared", 1'b0);

        // 3. auto-reload, N=3, period 5
        bus_wr(4'h4, 4'hF, 32'd3);
        bus_wr(4'h0, 4'hF, 32'hB);
        step(2);
        rd_check("rl_count_e2", 4'h8, 32'd3);
        step(3);
        rd_check("rl_count_e5", 4'h8, 32'd0);
        irq_check("rl_irq_e5", 1'b0);
        step(1);
        irq_check("rl_irq_e6", 1'b1);
        step(1);
        irq_check("rl_irq_e7", 1'b0);
        rd_check("rl_reload_e7", 4'h8, 32'd3);
        step(3);
        irq_check("rl_irq_e10", 1'b0);
        step(1);
        irq_check("rl_irq_e11", 1'b1);
        bus_wr(4'h0, 4'hF, 32'h0);
        step(2);
        rd_check("rl_count_stopped", 4'h8, 32'd3);

        // 4. byte-lane merge, ignored writes
        bus_wr(4'h4, 4'hF, 32'h11223344);
        bus_wr(4'h4, 4'b0010, 32'hAABBCCDD);
        rd_check("be_preset", 4'h4, 32'h1122CC44);
        bus_wr(4'h8, 4'hF, 32'hFFFFFFFF);
        rd_check("count_ro", 4'h8, 32'd3);
        bus_wr(4'hC, 4'hF, 32'hFFFFFFFF);
        rd_check("ofs_c_zero", 4'hC, 32'h0);
        rd_check("ctrl_upper_zero", 4'h0, 32'h0);
        bus_wr(4'h0, 4'hF, 32'hFFFFFFF0);
        rd_check("ctrl_upper_ignored", 4'h0, 32'h0);

        // 5. IM=0 masks expiry; CTRL write clears the hidden pending flag
        bus_wr(4'h4, 4'hF, 32'd2);
        bus_wr(4'h0, 4'hF, 32'h1);
        step(5);
        irq_check("mask_irq_e5", 1'b0);
        rd_check("mask_ctrl_e5", 4'h0, 32'h0);
        bus_wr(4'h0, 4'hF, 32'h8);
        irq_check("mask_unmask_clr", 1'b0);
        step(2);
        irq_check("mask_unmask_hold", 1'b0);

        // 6. EN cleared mid-count holds COUNT
        bus_wr(4'h4, 4'hF, 32'd20);
        bus_wr(4'h0, 4'hF, 32'h1);
        step(14);
        rd_check("stop_count_8", 4'h8, 32'd8);
        bus_wr(4'h0, 4'hF, 32'h0);
        rd_check("stop_count_7", 4'h8, 32'd7);
        step(3);
        rd_check("stop_count_hold", 4'h8, 32'd7);

        // async reset during counting
        bus_wr(4'h0, 4'hF, 32'h1);
        step(4);
        rd_check("arst_pre_count", 4'h8, 32'd18);
        #2;
        reset = 1'b0;
        #1;
        rd_check("arst_count", 4'h8, 32'h0);
        rd_check("arst_preset", 4'h4, 32'h0);
        rd_check("arst_ctrl", 4'h0, 32'h0);
        irq_check("arst_irq", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(3);
        rd_check("arst_idle_count", 4'h8, 32'h0);
        irq_check("arst_idle_irq", 1'b0);

        // 7. PRESET=0 acts as 1; then reset drops a live irq at once
        bus_wr(4'h0, 4'hF, 32'h9);
        step(2);
        rd_check("p0_count_e2", 4'h8, 32'h0);
        step(1);
        irq_check("p0_irq_e3", 1'b0);
        step(1);
        irq_check("p0_irq_e4", 1'b1);
        #2;
        reset = 1'b0;
        #1;
        irq_check("p0_irq_reset", 1'b0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
